ex_result_stage: RTL and testbench

- Registered stage directly downstream of the 64-bit ALU logic functions (OR/AND/XOR/adder result mux).
- Captures each ALU result with its destination info and derives N/Z per entry.
- Buffers entries in a 2-entry skid buffer under a valid/ready handshake, and commits the ARM NZCV flag register when a flag-setting entry leaves the stage.
- Feeds the MEM/writeback side and the conditional-branch logic.

---
 rtl/ex_result_stage.sv | 145 ++++++++++++++
 tb/tb_ex_result_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_result_stage.sv
// ex_result_stage: registered stage behind the 64-bit ALU result mux.
// Each captured result carries its destination info and N/Z/C/V, derived at
// capture. Entries sit in a 2-entry skid buffer (main + skid) under a
// valid/ready handshake. The NZCV register commits when a flag-setting entry
// leaves the stage.
// Optional feature: define FLAG_FORWARD_EN to bypass the committing entry's
// NZCV straight onto flag_n/z/c/v in the cycle it transfers.
module ex_result_stage #(
   parameter int WIDTH  = 64,
   parameter int DEST_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_result,
   input  logic              in_carry,
   input  logic              in_overflow,
   input  logic              in_setflags,
   input  logic [DEST_W-1:0] in_dest,
   input  logic              in_regwrite,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_result,
   output logic [DEST_W-1:0] out_dest,
   output logic              out_regwrite,
   output logic              out_zero,
   output logic              flag_n,
   output logic              flag_z,
   output logic              flag_c,
   output logic              flag_v
);

   // Entry layout: {setflags, regwrite, nzcv[3:0], dest, result}
   localparam int DEST_LO = WIDTH;
   localparam int NZCV_LO = WIDTH + DEST_W;
   localparam int RW_BIT  = NZCV_LO + 4;
   localparam int SF_BIT  = NZCV_LO + 5;
   localparam int E_W     = WIDTH + DEST_W + 6;

   logic           main_valid_q, main_valid_d;
   logic           skid_valid_q, skid_valid_d;
   logic [E_W-1:0] main_entry_q, main_entry_d;
   logic [E_W-1:0] skid_entry_q, skid_entry_d;
   logic [3:0]     nzcv_q, nzcv_d;

   logic           in_accept;
   logic           out_xfer;
   logic [3:0]     in_nzcv;
   logic [E_W-1:0] in_entry;
   logic [3:0]     main_nzcv;
   logic [3:0]     flags_out;

   assign main_nzcv = main_entry_q[NZCV_LO +: 4];

   // Pack the incoming entry and derive its flags; work out this cycle's handshakes
   always_comb begin
      in_nzcv   = {in_result[WIDTH-1], ~|in_result, in_carry, in_overflow};
      in_entry  = {in_setflags, in_regwrite, in_nzcv, in_dest, in_result};
      in_accept = in_valid && !skid_valid_q;
      out_xfer  = main_valid_q && out_ready;
   end

   // Next-state for the main/skid buffer and the committed flag register
   always_comb begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_entry_d = main_entry_q;
      skid_entry_d = skid_entry_q;
      nzcv_d       = nzcv_q;

      // A leaving flag-setting entry commits even during a flush.
      if (out_xfer && main_entry_q[SF_BIT]) begin
         nzcv_d = main_nzcv;
      end

      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (out_xfer) begin
         if (skid_valid_q) begin
            // in_ready is low while skid is full, so no accept can coincide.
            main_entry_d = skid_entry_q;
            skid_valid_d = 1'b0;
         end else if (in_accept) begin
            main_entry_d = in_entry;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (in_accept) begin
         if (!main_valid_q) begin
            main_entry_d = in_entry;
            main_valid_d = 1'b1;
         end else begin
            skid_entry_d = in_entry;
            skid_valid_d = 1'b1;
         end
      end
   end

   // State registers, cleared immediately on reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_entry_q <= '0;
         skid_entry_q <= '0;
         nzcv_q       <= 4'b0000;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_entry_q <= main_entry_d;
         skid_entry_q <= skid_entry_d;
         nzcv_q       <= nzcv_d;
      end
   end

`ifdef FLAG_FORWARD_EN
   // Show the committing entry's flags in the same cycle it transfers
   always_comb begin
      flags_out = nzcv_q;
      if (out_xfer && main_entry_q[SF_BIT]) begin
         flags_out = main_nzcv;
      end
   end
`else
   // Flags come straight from the committed register
   always_comb begin
      flags_out = nzcv_q;
   end
`endif

   assign in_ready     = !skid_valid_q;
   assign out_valid    = main_valid_q;
   assign out_result   = main_entry_q[WIDTH-1:0];
   assign out_dest     = main_entry_q[DEST_LO +: DEST_W];
   assign out_regwrite = main_entry_q[RW_BIT];
   assign out_zero     = main_nzcv[2];
   assign flag_n       = flags_out[3];
   assign flag_z       = flags_out[2];
   assign flag_c       = flags_out[1];
   assign flag_v       = flags_out[0];

endmodule

// File: tb/tb_ex_result_stage.sv
// Testbench for ex_result_stage: directed table, hand-written flag/flush/reset
// sequences, then randomized traffic against a queue-based reference model.
module tb_ex_result_stage;

   localparam int WIDTH  = 64;
   localparam int DEST_W = 5;
`ifdef FLAG_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid, in_ready;
   logic [WIDTH-1:0]  in_result;
   logic              in_carry, in_overflow, in_setflags, in_regwrite;
   logic [DEST_W-1:0] in_dest;
   logic              flush;
   logic              out_valid, out_ready;
   logic [WIDTH-1:0]  out_result;
   logic [DEST_W-1:0] out_dest;
   logic              out_regwrite, out_zero;
   logic              flag_n, flag_z, flag_c, flag_v;

   int checks = 0;
   int errors = 0;

   ex_result_stage #(.WIDTH(WIDTH), .DEST_W(DEST_W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_carry(in_carry), .in_overflow(in_overflow),
      .in_setflags(in_setflags), .in_dest(in_dest), .in_regwrite(in_regwrite),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_dest(out_dest), .out_regwrite(out_regwrite),
      .out_zero(out_zero),
      .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] flags();
      return {flag_n, flag_z, flag_c, flag_v};
   endfunction

   task automatic drive(input logic iv, input logic [63:0] res, input logic c, input logic v,
                        input logic sf, input logic [4:0] d, input logic rw,
                        input logic fl, input logic ordy);
      in_valid = iv; in_result = res; in_carry = c; in_overflow = v;
      in_setflags = sf; in_dest = d; in_regwrite = rw; flush = fl; out_ready = ordy;
   endtask

   // Directed table: inputs for one cycle, outputs expected in that cycle
   typedef struct {
      logic        iv;
      logic [63:0] res;
      logic        ordy;
      logic        e_ov;
      logic [63:0] e_res;
      logic        e_ir;
   } vec_t;
   vec_t tbl[12];

   // Reference model entry
   typedef struct {
      logic [63:0] res;
      logic [4:0]  dest;
      logic        rw;
      logic        sf;
      logic [3:0]  nzcv;
   } ent_t;
   ent_t        mq[$];
   logic [3:0]  m_nzcv;

   initial begin
      // back-to-back flow
      tbl[0]  = '{1'b1, 64'h1, 1'b1, 1'b0, 64'h0, 1'b1};
      tbl[1]  = '{1'b1, 64'h2, 1'b1, 1'b1, 64'h1, 1'b1};
      tbl[2]  = '{1'b1, 64'h3, 1'b1, 1'b1, 64'h2, 1'b1};
      tbl[3]  = '{1'b0, 64'h0, 1'b1, 1'b1, 64'h3, 1'b1};
      tbl[4]  = '{1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1};
      // backpressure
      tbl[5]  = '{1'b1, 64'hA, 1'b0, 1'b0, 64'h0, 1'b1};
      tbl[6]  = '{1'b1, 64'hB, 1'b0, 1'b1, 64'hA, 1'b1};
      tbl[7]  = '{1'b0, 64'h0, 1'b0, 1'b1, 64'hA, 1'b0};
      tbl[8]  = '{1'b0, 64'h0, 1'b0, 1'b1, 64'hA, 1'b0};
      tbl[9]  = '{1'b0, 64'h0, 1'b1, 1'b1, 64'hA, 1'b0};
      tbl[10] = '{1'b0, 64'h0, 1'b1, 1'b1, 64'hB, 1'b1};
      tbl[11] = '{1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1};

      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_result", out_result, 64'd0);
      chk("rst_out_dest", 64'(out_dest), 64'd0);
      chk("rst_flags", 64'(flags()), 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // ---- table-driven directed vectors ----
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         drive(tbl[i].iv, tbl[i].res, 0, 0, 0, 5'(i), 1'b1, 0, tbl[i].ordy);
         #1;
         chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
         chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_ir));
         if (tbl[i].e_ov) begin
            chk($sformatf("tbl%0d_out_result", i), out_result, tbl[i].e_res);
            chk($sformatf("tbl%0d_out_zero", i), 64'(out_zero), 64'd0);
         end
         $display("tbl%0d: iv=%0b res=0x%0h ordy=%0b -> ov=%0b out=0x%0h ir=%0b",
                  i, tbl[i].iv, tbl[i].res, tbl[i].ordy, out_valid, out_result, in_ready);
      end

      // ---- flag sequence: SUBS 0 (c=1), ADDS 0x8000.. (v=1), ORR no setflags ----
      @(negedge clk);
      drive(1, 64'h0, 1, 0, 1, 5'd1, 1, 0, 1);
      @(negedge clk);
      drive(1, 64'h8000_0000_0000_0000, 0, 1, 1, 5'd2, 1, 0, 1);
      #1;
      chk("flg_subs_zero", 64'(out_zero), 64'd1);
      chk("flg_subs_fwd", 64'(flags()), FWD ? 64'b0110 : 64'b0000);
      @(negedge clk);
      drive(1, 64'h0F, 1, 1, 0, 5'd3, 1, 0, 1);
      #1;
      chk("flg_adds_zero", 64'(out_zero), 64'd0);
      chk("flg_after_subs", 64'(flags()), FWD ? 64'b1001 : 64'b0110);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      #1;
      chk("flg_orr_zero", 64'(out_zero), 64'd0);
      chk("flg_after_adds", 64'(flags()), 64'b1001);
      @(negedge clk);
      #1;
      chk("flg_after_orr", 64'(flags()), 64'b1001);
      chk("flg_drained", 64'(out_valid), 64'd0);
      $display("flags: nzcv=%b", flags());

      // ---- flush with two entries buffered and a concurrent input ----
      @(negedge clk);
      drive(1, 64'h11, 1, 1, 1, 5'd4, 1, 0, 0);
      @(negedge clk);
      drive(1, 64'h22, 0, 0, 1, 5'd5, 1, 0, 0);
      @(negedge clk);
      drive(1, 64'h5, 0, 0, 1, 5'd6, 1, 1, 0);
      #1;
      chk("fl_full_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      #1;
      chk("fl_out_valid", 64'(out_valid), 64'd0);
      chk("fl_in_ready", 64'(in_ready), 64'd1);
      chk("fl_flags", 64'(flags()), 64'b1001);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         chk($sformatf("fl_no5_%0d", k), 64'(out_valid), 64'd0);
      end
      $display("flush: ov=%0b ir=%0b nzcv=%b", out_valid, in_ready, flags());

      // ---- reset mid-stream with main and skid full ----
      @(negedge clk);
      drive(1, 64'h33, 0, 0, 0, 5'd7, 1, 0, 0);
      @(negedge clk);
      drive(1, 64'h44, 0, 0, 0, 5'd8, 1, 0, 0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("rm_pre_in_ready", 64'(in_ready), 64'd0);
      reset = 1'b1;
      #1;
      chk("rm_out_valid", 64'(out_valid), 64'd0);
      chk("rm_in_ready", 64'(in_ready), 64'd1);
      chk("rm_flags", 64'(flags()), 64'd0);
      chk("rm_out_result", out_result, 64'd0);
      $display("reset mid-stream: ov=%0b ir=%0b nzcv=%b", out_valid, in_ready, flags());
      @(negedge clk);
      reset = 1'b0;
      m_nzcv = 4'b0000;
      mq.delete();

      // ---- randomized traffic against reference model ----
      for (int cyc = 0; cyc < 500; cyc++) begin
         logic        iv, ordy, fl, c, v, sf, rw, xfer, acc;
         logic [63:0] res;
         logic [4:0]  d;
         logic [3:0]  e_flags;
         int          sel;
         @(negedge clk);
         iv   = ($urandom_range(0, 9) < 7);
         ordy = ($urandom_range(0, 9) < 6);
         fl   = ($urandom_range(0, 19) == 0);
         c    = 1'($urandom);
         v    = 1'($urandom);
         sf   = 1'($urandom);
         rw   = 1'($urandom);
         d    = 5'($urandom);
         sel  = $urandom_range(0, 3);
         res  = (sel == 0) ? 64'h0 : {32'($urandom), 32'($urandom)};
         if (sel == 1) res[63] = 1'b1;
         drive(iv, res, c, v, sf, d, rw, fl, ordy);
         #1;
         xfer = (mq.size() > 0) && ordy;
         acc  = iv && (mq.size() < 2);
         e_flags = (FWD && xfer && mq[0].sf) ? mq[0].nzcv : m_nzcv;
         chk("rnd_out_valid", 64'(out_valid), 64'(mq.size() > 0));
         chk("rnd_in_ready", 64'(in_ready), 64'(mq.size() < 2));
         chk("rnd_flags", 64'(flags()), 64'(e_flags));
         if (mq.size() > 0) begin
            chk("rnd_out_result", out_result, mq[0].res);
            chk("rnd_out_dest", 64'(out_dest), 64'(mq[0].dest));
            chk("rnd_out_regwrite", 64'(out_regwrite), 64'(mq[0].rw));
            chk("rnd_out_zero", 64'(out_zero), 64'(mq[0].res == 64'd0));
         end
         if (cyc % 50 == 0)
            $display("rnd%0d: depth=%0d ov=%0b out=0x%0h nzcv=%b", cyc, mq.size(),
                     out_valid, out_result, flags());
         // model update for the coming edge
         if (xfer) begin
            if (mq[0].sf) m_nzcv = mq[0].nzcv;
            void'(mq.pop_front());
         end
         if (fl) mq.delete();
         else if (acc) mq.push_back('{res, d, rw, sf, {res[63], res == 64'd0, c, v}});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
